// File: rtl/al_accel_pu_grid_if.sv
// al_accel_pu_grid_if: weight write, window update, start and result handshake bundle
interface al_accel_pu_grid_if #(
  parameter int DATA_W = 8,
  parameter int K = 3,
  parameter int N_PU = 3,
  parameter int ACC_W = 20
);
  localparam int PU_W = N_PU > 1 ? $clog2(N_PU) : 1;
  localparam int IDX_W = $clog2(K * K);
  localparam int ROW_W = $clog2(K);
  logic wr_en;
  logic [PU_W-1:0] wr_pu;
  logic [IDX_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic in_valid;
  logic in_ready;
  logic [1:0] in_dir;
  logic [ROW_W-1:0] in_row;
  logic [K*DATA_W-1:0] in_vec;
  logic start;
  logic acc_keep;
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [N_PU*ACC_W-1:0] out_data;
  logic [N_PU-1:0] out_sat;
  modport master (
    output wr_en, wr_pu, wr_idx, wr_data, in_valid, in_dir, in_row, in_vec, start, acc_keep, out_ready,
    input in_ready, busy, out_valid, out_data, out_sat
  );
  modport slave (
    input wr_en, wr_pu, wr_idx, wr_data, in_valid, in_dir, in_row, in_vec, start, acc_keep, out_ready,
    output in_ready, busy, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/al_accel_pu_grid.sv
// al_accel_pu_grid: KxK shifting window shared by N_PU weight banks, row-serial saturating MAC
module al_accel_pu_grid #(
  parameter int DATA_W = 8,
  parameter int K = 3,
  parameter int N_PU = 3,
  parameter int ACC_W = 20
) (
  input logic clk,
  input logic reset,
  al_accel_pu_grid_if.slave bus
);
  localparam int PU_W = N_PU > 1 ? $clog2(N_PU) : 1;
  localparam int IDX_W = $clog2(K * K);
  localparam int ROW_W = $clog2(K);
  localparam int SUM_W = 2 * DATA_W + $clog2(K);
  localparam int EXT_W = ACC_W + 1;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q;
  logic signed [DATA_W-1:0] win_q [K][K];
  logic signed [DATA_W-1:0] win_d [K][K];
  logic signed [DATA_W-1:0] w_q [N_PU][K][K];
  logic signed [ACC_W-1:0] acc_q [N_PU];
  logic signed [ACC_W-1:0] acc_d [N_PU];
  logic signed [SUM_W-1:0] rsum [N_PU];
  logic signed [EXT_W-1:0] ext [N_PU];
  logic [N_PU-1:0] sat_q, ovf;
  logic idle, go;
  assign idle = state_q == IDLE;
  assign go = idle && bus.start;
  assign bus.in_ready = idle;
  assign bus.busy = !idle;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_sat = sat_q;
  for (genvar g = 0; g < N_PU; g++) begin : g_out
    assign bus.out_data[g*ACC_W +: ACC_W] = acc_q[g];
  end
  always_comb begin
    state_d = go ? MAC
            : (state_q == MAC && row_q == ROW_W'(K - 1)) ? DONE
            : (state_q == DONE && bus.out_ready) ? IDLE
            : state_q;
  end
  // Modulo indices keep every select in range; the wrapped value is never chosen at the edge.
  always_comb begin
    win_d = win_q;
    if (idle && bus.in_valid)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_d[r][c] = bus.in_dir == 2'd0 ? (bus.in_row == ROW_W'(r) ? bus.in_vec[c*DATA_W +: DATA_W] : win_q[r][c])
                      : bus.in_dir == 2'd1 ? (c == K - 1 ? bus.in_vec[r*DATA_W +: DATA_W] : win_q[r][(c+1)%K])
                      : bus.in_dir == 2'd2 ? (c == 0 ? bus.in_vec[r*DATA_W +: DATA_W] : win_q[r][(c+K-1)%K])
                      : (r == K - 1 ? bus.in_vec[c*DATA_W +: DATA_W] : win_q[(r+1)%K][c]);
  end
  // One extra accumulator bit exposes overflow as a mismatch of the two top bits.
  always_comb begin
    for (int p = 0; p < N_PU; p++) begin
      rsum[p] = '0;
      for (int c = 0; c < K; c++)
        rsum[p] = rsum[p] + SUM_W'(w_q[p][row_q][c]) * SUM_W'(win_q[row_q][c]);
      ext[p] = EXT_W'(acc_q[p]) + EXT_W'(rsum[p]);
      ovf[p] = ext[p][ACC_W] != ext[p][ACC_W-1];
      acc_d[p] = !ovf[p] ? ext[p][ACC_W-1:0]
               : ext[p][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
               : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      sat_q <= '0;
      win_q <= '{default: '0};
      w_q <= '{default: '0};
      acc_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      if (idle && bus.wr_en)
        for (int p = 0; p < N_PU; p++)
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              if (bus.wr_pu == PU_W'(p) && bus.wr_idx == IDX_W'(r * K + c))
                w_q[p][r][c] <= bus.wr_data;
      if (go) begin
        row_q <= '0;
        if (!bus.acc_keep) begin
          sat_q <= '0;
          acc_q <= '{default: '0};
        end
      end else if (state_q == MAC) begin
        row_q <= row_q + ROW_W'(1);
        sat_q <= sat_q | ovf;
        acc_q <= acc_d;
      end
    end
  end
endmodule

// File: doc/al_accel_pu_grid.md
# al_accel_pu_grid

Parametrised successor to the fixed 3x3 processing-unit array in the accelerator datapath. It holds a KxK input window register with directional shift (LEFT/RIGHT/DOWN) for sliding convolution and one KxK signed weight bank per PU across N_PU output channels. Each PU computes a saturating multiply-accumulate over the window, one window row per cycle, and returns the results on a valid/ready output handshake. An accumulate-keep mode lets partial sums carry across successive input channels.

## Interface
- DATA_W, 8, signed weight/activation width
- K, 3, window edge (K>=2)
- N_PU, 3, number of PUs / output channels
- ACC_W, 20, signed accumulator width; must be >= 2*DATA_W + clog2(K*K)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  weight write strobe
- wr_pu  in  max(1,clog2(N_PU))  target PU
- wr_idx  in  clog2(K*K)  weight index, row-major (r*K+c)
- wr_data  in  DATA_W  weight value
- in_valid  in  1  window update request
- in_ready  out  1  window update/start accepted (high only in IDLE)
- in_dir  in  2  00 NON (row load), 01 LEFT, 10 RIGHT, 11 DOWN
- in_row  in  clog2(K)  row index for NON
- in_vec  in  K*DATA_W  K new elements, element i at bits [i*DATA_W +: DATA_W]
- start  in  1  begin MAC on current window
- acc_keep  in  1  sampled with start: 1 continues from the previous result, 0 starts from 0
- busy  out  1  state != IDLE
- out_valid  out  1  results available
- out_ready  in  1  consumer accepts results
- out_data  out  N_PU*ACC_W  PU p result at [p*ACC_W +: ACC_W]
- out_sat  out  N_PU  per-PU sticky saturation flag for the current result

## Operation
- FSM states: IDLE -> MAC (start accepted) -> DONE (after K MAC cycles) -> IDLE (out_valid && out_ready).
- wr_en, in_valid and start are acted on only in IDLE and ignored otherwise. No queuing.
- Window update, with x[r][c] at row r, column c:
  - NON: x[in_row][c] <= in_vec[c].
  - LEFT: x[r][c] <= x[r][c+1]; x[r][K-1] <= in_vec[r].
  - RIGHT: x[r][c] <= x[r][c-1]; x[r][0] <= in_vec[r].
  - DOWN: x[r][c] <= x[r+1][c]; x[K-1][c] <= in_vec[c].
- MAC: a row counter runs 0..K-1. Each cycle, for every PU p: acc_p <= sat(acc_p + sum_c w_p[r][c]*x[r][c]).
  - Products and the row sum are computed at full width (2*DATA_W + clog2(K)).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets out_sat[p].
- On start: acc_keep=0 clears acc_p and out_sat. acc_keep=1 keeps both.
- out_data mirrors acc_p directly. It is stable while out_valid is high.
- Simultaneous events in IDLE:
  - wr_en, in_valid and start in the same cycle are all accepted.
  - The MAC uses the updated weights and window.
- Reset clears all weights, the window, the accumulators and out_sat to 0, and sets the state to IDLE, including when asserted mid-MAC or in DONE.

## Timing
- Reset values: in_ready=1, busy=0, out_valid=0, out_data=0, out_sat=0.
- Start sampled at edge 0: busy=1 from edge 0; MAC occupies edges 1..K; out_valid=1 after edge K (latency K+1 cycles).
- out_valid holds until handshake. Handshake at edge j: IDLE, out_valid=0, in_ready=1 after edge j.
- Minimum period: K+2 cycles per window.
- A window or weight update is visible to a start in the next cycle.

## Test plan
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle during MAC row 1.
  - Required: next cycle busy=0, out_valid=0, in_ready=1, out_data=0; a following start on the zeroed window returns 0 for all PUs.
- Basic MAC:
  - Stimulus: K=3, all weights 1, three NON loads of {2,2,2}, start.
  - Required: out_valid rises 4 cycles after start; every PU reads 18, out_sat=0.
- LEFT shift:
  - Stimulus: PU0 weight w[0][2]=1, all others 0; rows {1,2,3}; LEFT with in_vec {7,8,9}; start.
  - Required: PU0=7.
  - Then RIGHT with {5,5,5} and start with weight w[0][0]=1 only: PU0=5.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles after out_valid, with in_valid/start/wr_en pulsed during the stall.
  - Required: out_valid and out_data stable; window and weights unchanged; in_ready=0.
- Accumulate-keep:
  - Stimulus: weights 1, window 1.
  - Required: start(acc_keep=0) gives 9; start(acc_keep=1) gives 18; start(acc_keep=0) gives 9.
- Saturation:
  - Stimulus: weights -128, window -128 (each pass adds 147456); four starts, the first with acc_keep=0, then acc_keep=1.
  - Required: results 147456, 294912, 442368, then 524287 with out_sat[p]=1; the next acc_keep=0 start clears out_sat.
